// File: rtl/ptosda_param.sv
// Parallel-to-serial two-wire framer: valid/ready word in, start/data/stop frame out on scl/sda.
// Optional even-parity bit after the data bits when PTOSDA_PARITY_EN is defined.
module ptosda_param #(
    parameter int DATA_W    = 4,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              scl,
    output logic              sda_o,
    output logic              sda_oe,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LINK     = 3'd1,
        BITS     = 3'd2,
`ifdef PTOSDA_PARITY_EN
        PAR      = 3'd3,
`endif
        PRE_STOP = 3'd4,
        STOP     = 3'd5,
        RELEASE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              scl_q, scl_d;
    logic              sda_q, sda_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic              mid;
    logic              nxt_bit;
    logic [DATA_W-1:0] shifted;
`ifdef PTOSDA_PARITY_EN
    logic              par_q, par_d;
`endif

    // Free-running scl; mid sits halfway between scl edges so sda never moves with scl.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        scl_d = (cnt_q == CNT_MAX) ? ~scl_q : scl_q;
        mid   = (cnt_q == CNT_MID);
    end

    always_comb begin
        nxt_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
        shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end

    always_comb begin
        state_d  = state_q;
        sda_d    = sda_q;
        done_d   = 1'b0;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef PTOSDA_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                sda_d = 1'b1;
                if (data_valid) begin
                    shreg_d = data_in;
`ifdef PTOSDA_PARITY_EN
                    par_d   = ^data_in;
`endif
                    state_d = LINK;
                end
            end
            LINK: begin
                if (mid && scl_q) begin
                    sda_d    = 1'b0;
                    bitcnt_d = BIT_TOP;
                    state_d  = BITS;
                end
            end
            BITS: begin
                if (mid && !scl_q) begin
                    sda_d   = nxt_bit;
                    shreg_d = shifted;
                    if (bitcnt_q == '0) begin
`ifdef PTOSDA_PARITY_EN
                        state_d = PAR;
`else
                        state_d = PRE_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q - BW'(1);
                    end
                end
            end
`ifdef PTOSDA_PARITY_EN
            PAR: begin
                if (mid && !scl_q) begin
                    sda_d   = par_q;
                    state_d = PRE_STOP;
                end
            end
`endif
            PRE_STOP: begin
                if (mid && !scl_q) begin
                    sda_d   = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (mid && scl_q) begin
                    sda_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                sda_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            done_q   <= 1'b0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            done_q   <= done_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

`ifdef PTOSDA_PARITY_EN
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign sda_oe     = (state_q != IDLE);
    assign scl        = scl_q;
    assign sda_o      = sda_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ptosda_param.sv
// Bench for ptosda_param: three configurations, frames decoded off the wire and matched against a scoreboard.
module tb_ptosda_param;
    logic       sclk = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] din0 = '0;
    logic [3:0] din1 = '0;
    logic [7:0] din2 = '0;
    logic [2:0] vld  = '0;
    wire  [2:0] rdy_v, scl_v, sda_v, oe_v, busy_v, done_v;

`ifdef PTOSDA_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   errs = 0, nchk = 0;
    int   edge_err = 0, done_cnt = 0, exp_frames = 0;
    bit   inf[3];
    bit   chk_rdy[3];
    int   n[3];
    logic [15:0] col[3];
    logic [2:0]  p_scl, p_sda, p_oe;

    always #5 sclk = ~sclk;

    ptosda_param u_dut (
        .sclk(sclk), .rst(rst), .data_in(din0), .data_valid(vld[0]), .data_ready(rdy_v[0]),
        .scl(scl_v[0]), .sda_o(sda_v[0]), .sda_oe(oe_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

    ptosda_param #(.DATA_W(4), .CLK_DIV(2), .MSB_FIRST(0)) u_lsb (
        .sclk(sclk), .rst(rst), .data_in(din1), .data_valid(vld[1]), .data_ready(rdy_v[1]),
        .scl(scl_v[1]), .sda_o(sda_v[1]), .sda_oe(oe_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

    ptosda_param #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) u_wide (
        .sclk(sclk), .rst(rst), .data_in(din2), .data_valid(vld[2]), .data_ready(rdy_v[2]),
        .scl(scl_v[2]), .sda_o(sda_v[2]), .sda_oe(oe_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected wire sequence as sampled on scl rising edges: data bits, optional parity, pre-stop zero.
    function automatic exp_t mk(input int inst, input logic [7:0] d);
        exp_t e;
        int   w;
        w      = (inst == 2) ? 8 : 4;
        e.inst = inst;
        e.bits = '0;
        e.len  = 0;
        for (int k = 0; k < w; k++) begin
            int idx;
            idx    = (inst == 1) ? k : w - 1 - k;
            e.bits = {e.bits[14:0], d[idx]};
            e.len++;
        end
        if (PAR_EN) begin
            e.bits = {e.bits[14:0], ^d};
            e.len++;
        end
        e.bits = {e.bits[14:0], 1'b0};
        e.len++;
        return e;
    endfunction

    always @(negedge sclk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                inf[i]     = 1'b0;
                chk_rdy[i] = 1'b0;
            end else begin
                if (chk_rdy[i]) begin
                    chk("rdy_after_done", rdy_v[i], 1);
                    chk_rdy[i] = 1'b0;
                end
                if (done_v[i]) done_cnt++;
                if (oe_v[i] && p_oe[i] && sda_v[i] != p_sda[i] && scl_v[i] != p_scl[i]) edge_err++;
                if (oe_v[i] && scl_v[i] && p_scl[i] && p_sda[i] && !sda_v[i]) begin
                    inf[i] = 1'b1;
                    n[i]   = 0;
                    col[i] = '0;
                    chk("start_busy", busy_v[i], 1);
                end else if (inf[i] && scl_v[i] && !p_scl[i]) begin
                    col[i] = {col[i][14:0], sda_v[i]};
                    n[i]++;
                end else if (inf[i] && oe_v[i] && scl_v[i] && p_scl[i] && !p_sda[i] && sda_v[i]) begin
                    inf[i] = 1'b0;
                    chk("stop_done", done_v[i], 1);
                    chk("stop_rdy", rdy_v[i], 0);
                    chk_rdy[i] = 1'b1;
                    if (sb.size() == 0) begin
                        chk("orphan_frame", sb.size(), 1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("frame_inst", i, e.inst);
                        chk("frame_len", n[i], e.len);
                        chk("frame_bits", col[i], e.bits);
                    end
                end
            end
        end
        p_scl = scl_v;
        p_sda = sda_v;
        p_oe  = oe_v;
    end

    task automatic chk_rst();
        for (int i = 0; i < 3; i++) begin
            chk("rst_scl", scl_v[i], 1);
            chk("rst_sda", sda_v[i], 1);
            chk("rst_oe", oe_v[i], 0);
            chk("rst_rdy", rdy_v[i], 1);
            chk("rst_busy", busy_v[i], 0);
            chk("rst_done", done_v[i], 0);
        end
    endtask

    task automatic send(input int inst, input logic [7:0] d, input bit hold);
        int t;
        t = 0;
        @(negedge sclk);
        case (inst)
            0: din0 = d[3:0];
            1: din1 = d[3:0];
            default: din2 = d;
        endcase
        vld[inst] = 1'b1;
        while (!rdy_v[inst] && t < 300) begin
            @(negedge sclk);
            t++;
        end
        chk("rdy_wait", rdy_v[inst], 1);
        chk("idle_oe", oe_v[inst], 0);
        sb.push_back(mk(inst, d));
        exp_frames++;
        @(posedge sclk);
        #1;
        chk("acc_busy", busy_v[inst], 1);
        chk("acc_rdy", rdy_v[inst], 0);
        if (!hold) vld[inst] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge sclk);
            t++;
        end
        chk("drain", sb.size(), 0);
        repeat (4) @(negedge sclk);
    endtask

    task automatic period(input int inst, input int exp);
        int t, c;
        t = 0;
        c = 0;
        @(negedge sclk);
        while (!(scl_v[inst] && !p_scl[inst]) && t < 50) begin
            @(negedge sclk);
            t++;
        end
        @(negedge sclk);
        c = 1;
        while (!(scl_v[inst] && !p_scl[inst]) && c < 50) begin
            @(negedge sclk);
            c++;
        end
        chk("scl_period", c, exp);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge sclk);
        #1;
        chk_rst();
        @(negedge sclk);
        rst = 1'b0;

        // single frame MSB first, then LSB first
        send(0, 8'h0A, 1'b0);
        drain();
        send(1, 8'h01, 1'b0);
        drain();

        // back-to-back with data change after capture
        send(0, 8'h0A, 1'b1);
        din0 = 4'h5;
        send(0, 8'h05, 1'b0);
        drain();

        // abort mid-frame with asynchronous reset
        send(0, 8'h0F, 1'b0);
        t = 0;
        while (!(inf[0] && n[0] >= 2) && t < 200) begin
            @(negedge sclk);
            t++;
        end
        chk("reached_bits", n[0], 2);
        @(posedge sclk);
        #2;
        rst = 1'b1;
        #1;
        chk_rst();
        if (sb.size() != 0) begin
            void'(sb.pop_back());
            exp_frames--;
        end
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        rst = 1'b0;
        @(posedge sclk); #1; chk("scl_r1", scl_v[0], 1);
        @(posedge sclk); #1; chk("scl_r2", scl_v[0], 0);
        @(posedge sclk); #1; chk("scl_r3", scl_v[0], 0);
        @(posedge sclk); #1; chk("scl_r4", scl_v[0], 1);
        send(0, 8'h03, 1'b0);
        drain();

        // wide configuration, parity when enabled
        send(2, 8'hB7, 1'b0);
        drain();
        send(2, 8'h01, 1'b0);
        drain();
        period(2, 8);
        period(0, 4);

        chk("edge_err", edge_err, 0);
        chk("done_cnt", done_cnt, exp_frames);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
